// File: rtl/calc_pkg.sv
// Shared constants for the keypad calculator: opcodes, execution states, default widths.
package calc_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int DIGITS_DEF = 5;

  // Keypad opcode values; the key-entry FSM decodes the same constants.
  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;
  localparam logic [3:0] OP_MOD = 4'hE;
  localparam logic [3:0] KEY_EQ = 4'hF;

  // Execution sequencer states.
  typedef logic [1:0] exec_state_t;
  localparam exec_state_t ST_IDLE = 2'd0;
  localparam exec_state_t ST_EXEC = 2'd1;
  localparam exec_state_t ST_CONV = 2'd2;
  localparam exec_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/calc_exec_ctrl_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one bit per clock.
// The first shift happens on the start edge, so OUT_done pulses WIDTH-1 edges later
// with OUT_bcd already holding the final digits.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  IN_clk,
  input  logic                  IN_reset,
  input  logic                  IN_start,
  input  logic [WIDTH-1:0]      IN_bin,
  output logic                  OUT_busy,
  output logic                  OUT_done,
  output logic [4*DIGITS-1:0]   OUT_bcd
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS + WIDTH;

  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // One double-dabble step: add 3 to every digit >= 5, then shift left by one bit.
  function automatic logic [SW-1:0] dabble_step(input logic [4*DIGITS-1:0] bcd,
                                                input logic [WIDTH-1:0] bin);
    logic [4*DIGITS-1:0] adj;
    logic [3:0]          dig;
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = bcd[4*i +: 4];
      adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
    return {adj, bin} << 1;
  endfunction

  // Load on start, otherwise keep shifting until the last bit has gone through.
  always_comb begin
    bcd_d  = bcd_q;
    bin_d  = bin_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (IN_start) begin
      {bcd_d, bin_d} = dabble_step('0, IN_bin);
      cnt_d          = CW'(WIDTH - 1);
      busy_d         = 1'b1;
    end else if (busy_q) begin
      {bcd_d, bin_d} = dabble_step(bcd_q, bin_q);
      cnt_d          = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge IN_clk or negedge IN_reset) begin
    if (!IN_reset) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      bin_q  <= bin_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign OUT_busy = busy_q;
  assign OUT_done = done_q;
  assign OUT_bcd  = bcd_q;

endmodule

// File: rtl/calc_exec_ctrl.sv
// Calculator execution sequencer: latches operands on the rising edge of the entry-finished
// flag, runs add/sub (1 cycle) or mul/div/mod (16 iterations) on a shared accumulator pair,
// then converts the result to BCD. Results hold until the next accepted start.
module calc_exec_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                IN_clk,
  input  logic                IN_reset,
  input  logic                IN_start,
  input  logic [WIDTH-1:0]    IN_src,
  input  logic [WIDTH-1:0]    IN_dst,
  input  logic [3:0]          IN_op,
  output logic                OUT_busy,
  output logic                OUT_valid,
  output logic                OUT_err,
  output logic                OUT_neg,
  output logic [WIDTH-1:0]    OUT_result,
  output logic [4*DIGITS-1:0] OUT_bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  exec_state_t         state_q, state_d;
  logic                start_prev_q, start_prev_d;
  logic [WIDTH-1:0]    src_q, src_d;
  logic [WIDTH-1:0]    dst_q, dst_d;
  logic [3:0]          op_q, op_d;
  logic [WIDTH-1:0]    acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]    acc_lo_q, acc_lo_d;
  logic [CW-1:0]       iter_q, iter_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                neg_q, neg_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;

  logic                start_rise;
  logic                conv_start;
  logic [WIDTH-1:0]    conv_bin;
  logic                conv_busy;
  logic                conv_done;
  logic [4*DIGITS-1:0] conv_bcd;

  logic [WIDTH:0]      add_sum;
  logic                src_lt;
  logic [WIDTH-1:0]    sub_mag;
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH-1:0]    mul_hi_n, mul_lo_n;
  logic [WIDTH:0]      rem_sh, rem_n;
  logic                div_ge;
  logic [WIDTH-1:0]    div_hi_n, div_lo_n;
  logic                last_iter;

  assign start_rise = IN_start & ~start_prev_q;

  // Datapath: single-cycle add/sub, one shift-add multiply step, one restoring-divide step.
  always_comb begin
    add_sum   = {1'b0, src_q} + {1'b0, dst_q};
    src_lt    = src_q < dst_q;
    sub_mag   = src_lt ? (dst_q - src_q) : (src_q - dst_q);
    // Multiply: acc_lo holds the multiplier, product bits shift in from the top.
    mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? src_q : '0)};
    mul_hi_n  = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    rem_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = rem_sh >= {1'b0, dst_q};
    rem_n     = div_ge ? (rem_sh - {1'b0, dst_q}) : rem_sh;
    div_hi_n  = rem_n[WIDTH-1:0];
    div_lo_n  = {acc_lo_q[WIDTH-2:0], div_ge};
    last_iter = (iter_q == CW'(WIDTH - 1));
  end

  // Sequencer next-state and output-register logic.
  always_comb begin
    logic             fin_ok;
    logic             fin_err;
    logic [WIDTH-1:0] fin_val;
    logic             fin_neg;

    state_d      = state_q;
    start_prev_d = IN_start;
    src_d        = src_q;
    dst_d        = dst_q;
    op_d         = op_q;
    acc_hi_d     = acc_hi_q;
    acc_lo_d     = acc_lo_q;
    iter_d       = iter_q;
    busy_d       = busy_q;
    valid_d      = valid_q;
    err_d        = err_q;
    neg_d        = neg_q;
    result_d     = result_q;
    bcd_d        = bcd_q;
    conv_start   = 1'b0;
    conv_bin     = '0;
    fin_ok       = 1'b0;
    fin_err      = 1'b0;
    fin_val      = '0;
    fin_neg      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_rise) begin
          src_d    = IN_src;
          dst_d    = IN_dst;
          op_d     = IN_op;
          acc_hi_d = '0;
          acc_lo_d = (IN_op == OP_MUL) ? IN_dst : IN_src;
          iter_d   = '0;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
          err_d    = 1'b0;
          neg_d    = 1'b0;
          result_d = '0;
          bcd_d    = '0;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_ADD: begin
            if (add_sum[WIDTH]) fin_err = 1'b1;
            else begin
              fin_ok  = 1'b1;
              fin_val = add_sum[WIDTH-1:0];
            end
          end
          OP_SUB: begin
            fin_ok  = 1'b1;
            fin_val = sub_mag;
            fin_neg = src_lt;
          end
          OP_MUL: begin
            acc_hi_d = mul_hi_n;
            acc_lo_d = mul_lo_n;
            iter_d   = iter_q + CW'(1);
            if (last_iter) begin
              if (mul_hi_n != '0) fin_err = 1'b1;
              else begin
                fin_ok  = 1'b1;
                fin_val = mul_lo_n;
              end
            end
          end
          OP_DIV, OP_MOD: begin
            if (iter_q == '0 && dst_q == '0) fin_err = 1'b1;
            else begin
              acc_hi_d = div_hi_n;
              acc_lo_d = div_lo_n;
              iter_d   = iter_q + CW'(1);
              if (last_iter) begin
                fin_ok  = 1'b1;
                fin_val = (op_q == OP_DIV) ? div_lo_n : div_hi_n;
              end
            end
          end
          default: fin_err = 1'b1;
        endcase
      end
      ST_CONV: begin
        if (conv_done && !conv_busy) begin
          bcd_d   = conv_bcd;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Errors skip conversion and report a zeroed result immediately.
    if (fin_err) begin
      err_d    = 1'b1;
      result_d = '0;
      neg_d    = 1'b0;
      bcd_d    = '0;
      busy_d   = 1'b0;
      valid_d  = 1'b1;
      state_d  = ST_DONE;
    end else if (fin_ok) begin
      result_d   = fin_val;
      neg_d      = fin_neg;
      conv_start = 1'b1;
      conv_bin   = fin_val;
      state_d    = ST_CONV;
    end
  end

  // State registers with asynchronous active-low reset; reset aborts any operation.
  always_ff @(posedge IN_clk or negedge IN_reset) begin
    if (!IN_reset) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      op_q         <= '0;
      acc_hi_q     <= '0;
      acc_lo_q     <= '0;
      iter_q       <= '0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      neg_q        <= 1'b0;
      result_q     <= '0;
      bcd_q        <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      op_q         <= op_d;
      acc_hi_q     <= acc_hi_d;
      acc_lo_q     <= acc_lo_d;
      iter_q       <= iter_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      neg_q        <= neg_d;
      result_q     <= result_d;
      bcd_q        <= bcd_d;
    end
  end

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .IN_clk   (IN_clk),
    .IN_reset (IN_reset),
    .IN_start (conv_start),
    .IN_bin   (conv_bin),
    .OUT_busy (conv_busy),
    .OUT_done (conv_done),
    .OUT_bcd  (conv_bcd)
  );

  assign OUT_busy   = busy_q;
  assign OUT_valid  = valid_q;
  assign OUT_err    = err_q;
  assign OUT_neg    = neg_q;
  assign OUT_result = result_q;
  assign OUT_bcd    = bcd_q;

endmodule

// File: tb/tb_calc_exec_ctrl.sv
// Self-checking bench for calc_exec_ctrl: directed cases plus random operations,
// compared every cycle against a behavioural model of the calculator.
module tb_calc_exec_ctrl;

  logic        IN_clk = 1'b0;
  logic        IN_reset = 1'b0;
  logic        IN_start = 1'b0;
  logic [15:0] IN_src = '0;
  logic [15:0] IN_dst = '0;
  logic [3:0]  IN_op = '0;
  logic        OUT_busy, OUT_valid, OUT_err, OUT_neg;
  logic [15:0] OUT_result;
  logic [19:0] OUT_bcd;

  int checks = 0;
  int failures = 0;
  bit check_en = 0;

  calc_exec_ctrl #(.WIDTH(16), .DIGITS(5)) dut (
    .IN_clk     (IN_clk),
    .IN_reset   (IN_reset),
    .IN_start   (IN_start),
    .IN_src     (IN_src),
    .IN_dst     (IN_dst),
    .IN_op      (IN_op),
    .OUT_busy   (OUT_busy),
    .OUT_valid  (OUT_valid),
    .OUT_err    (OUT_err),
    .OUT_neg    (OUT_neg),
    .OUT_result (OUT_result),
    .OUT_bcd    (OUT_bcd)
  );

  always #5 IN_clk = ~IN_clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] b;
    b = '0;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  // Arithmetic meaning of each opcode plus the documented latency to valid.
  task automatic calc(input int unsigned s, input int unsigned d, input logic [3:0] op,
                      output int unsigned res, output bit err, output bit neg, output int lat);
    longint unsigned p;
    res = 0; err = 0; neg = 0; lat = 1;
    case (op)
      4'hA: begin
        if (s + d > 65535) err = 1;
        else begin res = s + d; lat = 17; end
      end
      4'hB: begin
        if (s >= d) res = s - d;
        else begin res = d - s; neg = 1; end
        lat = 17;
      end
      4'hC: begin
        p = longint'(s) * longint'(d);
        if (p > 65535) begin err = 1; lat = 16; end
        else begin res = int'(p); lat = 32; end
      end
      4'hD, 4'hE: begin
        if (d == 0) err = 1;
        else begin res = (op == 4'hD) ? s / d : s % d; lat = 32; end
      end
      default: err = 1;
    endcase
  endtask

  // Behavioural model: outputs clear on an accepted start and land after the latency.
  bit          m_busy, m_valid, m_err, m_neg, m_start_d;
  int unsigned m_result;
  logic [19:0] m_bcd;
  int          m_cnt;
  int unsigned f_res;
  bit          f_err, f_neg;

  always @(posedge IN_clk or negedge IN_reset) begin
    int lat;
    if (!IN_reset) begin
      m_busy = 0; m_valid = 0; m_err = 0; m_neg = 0; m_start_d = 0;
      m_result = 0; m_bcd = '0; m_cnt = 0;
    end else begin
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_valid = 1;
          m_err = f_err; m_neg = f_neg; m_result = f_res;
          m_bcd = f_err ? 20'h0 : to_bcd(f_res);
        end
      end else if (IN_start && !m_start_d) begin
        calc(IN_src, IN_dst, IN_op, f_res, f_err, f_neg, lat);
        m_busy = 1; m_valid = 0; m_err = 0; m_neg = 0; m_result = 0; m_bcd = '0;
        m_cnt = lat;
      end
      m_start_d = IN_start;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge IN_clk) begin
    if (check_en && IN_reset) begin
      chk("busy", OUT_busy, m_busy);
      chk("valid", OUT_valid, m_valid);
      chk("err", OUT_err, m_err);
      chk("bcd", OUT_bcd, m_bcd);
      if (!m_busy) begin
        chk("result", OUT_result, m_result);
        chk("neg", OUT_neg, m_neg);
      end
    end
  end

  int last_lat;

  // Launch one operation, hold start for 'hold' cycles, optionally re-pulse start at cycle 'poke'.
  task automatic run_op(input logic [15:0] s, input logic [15:0] d, input logic [3:0] op,
                        input int hold, input int poke);
    int n;
    @(negedge IN_clk);
    IN_src = s; IN_dst = d; IN_op = op; IN_start = 1'b1;
    n = 0;
    last_lat = -1;
    while (n < 60) begin
      @(negedge IN_clk);
      n++;
      if (n == hold) IN_start = 1'b0;
      if (poke != 0 && n == poke) begin
        IN_start = 1'b1; IN_src = 16'(n * 77); IN_dst = 16'h0003; IN_op = 4'hA;
      end
      if (poke != 0 && n == poke + 2) IN_start = 1'b0;
      if (OUT_valid) begin
        last_lat = n - 1;
        break;
      end
    end
    IN_start = 1'b0;
    if (last_lat < 0) chk("timeout", 0, 1);
    @(negedge IN_clk);
  endtask

  initial begin
    int unsigned r_res;
    bit r_err, r_neg;
    int r_lat;
    logic [15:0] rs, rd;
    logic [3:0]  rop;

    repeat (2) @(negedge IN_clk);
    chk("rst_busy", OUT_busy, 0);
    chk("rst_valid", OUT_valid, 0);
    chk("rst_result", OUT_result, 0);
    chk("rst_bcd", OUT_bcd, 0);
    IN_reset = 1'b1;
    check_en = 1;
    repeat (2) @(negedge IN_clk);

    // Reset in the middle of a multiply.
    IN_src = 16'd200; IN_dst = 16'd300; IN_op = 4'hC; IN_start = 1'b1;
    @(posedge IN_clk);
    repeat (5) @(posedge IN_clk);
    #3 IN_reset = 1'b0;
    #1;
    chk("mrst_busy", OUT_busy, 0);
    chk("mrst_valid", OUT_valid, 0);
    chk("mrst_err", OUT_err, 0);
    chk("mrst_neg", OUT_neg, 0);
    chk("mrst_result", OUT_result, 0);
    chk("mrst_bcd", OUT_bcd, 0);
    @(negedge IN_clk);
    IN_start = 1'b0;
    @(negedge IN_clk);
    IN_reset = 1'b1;
    repeat (2) @(negedge IN_clk);

    // Directed cases with hand-computed expectations.
    run_op(16'd123, 16'd456, 4'hA, 10, 0);
    chk("add_lat", last_lat, 17);
    chk("add_res", OUT_result, 579);
    chk("add_bcd", OUT_bcd, 20'h00579);
    chk("add_err", OUT_err, 0);
    repeat (5) @(negedge IN_clk);
    chk("add_no_rerun", OUT_valid, 1);

    run_op(16'd12, 16'd999, 4'hB, 1, 0);
    chk("sub_res", OUT_result, 987);
    chk("sub_neg", OUT_neg, 1);
    chk("sub_bcd", OUT_bcd, 20'h00987);

    run_op(16'd999, 16'd999, 4'hC, 1, 0);
    chk("movf_lat", last_lat, 16);
    chk("movf_err", OUT_err, 1);
    chk("movf_res", OUT_result, 0);

    run_op(16'd255, 16'd255, 4'hC, 1, 0);
    chk("mul_lat", last_lat, 32);
    chk("mul_res", OUT_result, 65025);
    chk("mul_bcd", OUT_bcd, 20'h65025);

    run_op(16'd999, 16'd7, 4'hD, 1, 4);
    chk("div_lat", last_lat, 32);
    chk("div_res", OUT_result, 142);

    run_op(16'd999, 16'd7, 4'hE, 1, 0);
    chk("mod_res", OUT_result, 5);
    chk("mod_bcd", OUT_bcd, 20'h00005);

    run_op(16'd999, 16'd0, 4'hD, 1, 0);
    chk("dz_lat", last_lat, 1);
    chk("dz_err", OUT_err, 1);
    chk("dz_bcd", OUT_bcd, 0);

    run_op(16'd5, 16'd6, 4'h3, 1, 0);
    chk("ill_err", OUT_err, 1);
    chk("ill_lat", last_lat, 1);

    run_op(16'hFFFF, 16'd1, 4'hA, 1, 0);
    chk("addc_err", OUT_err, 1);

    // Random operations; the model catches content, this checks latency too.
    for (int k = 0; k < 40; k++) begin
      rop = ($urandom_range(0, 5) == 5) ? 4'($urandom) : 4'(4'hA + $urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) begin
        rs = 16'($urandom_range(0, 400)); rd = 16'($urandom_range(0, 300));
      end else begin
        rs = 16'($urandom); rd = 16'($urandom);
      end
      calc(rs, rd, rop, r_res, r_err, r_neg, r_lat);
      run_op(rs, rd, rop, $urandom_range(1, 4), ($urandom_range(0, 2) == 0) ? 3 : 0);
      chk("rnd_lat", last_lat, r_lat);
    end

    repeat (3) @(negedge IN_clk);
    check_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_exec_ctrl.md
Name: calc_exec_ctrl

Overview:
Execution sequencer for the keypad calculator. It sits downstream of the key-entry FSM and waits for that FSM's "entry finished" flag. It then latches the two operands and the opcode, runs the operation on a shared 16-bit add/shift datapath (single-cycle add/sub, iterative mul/div), and converts the result to 5-digit BCD for the display. Results are held stable until the next entry completes.

Parameters:
WIDTH, 16, operand/result width in bits
DIGITS, 5, BCD digits of converted result (must cover 2^WIDTH-1)

Ports:
IN_clk  input  1  system clock
IN_reset  input  1  asynchronous, active-low reset
IN_start  input  1  entry-finished flag from key-entry ctrl byte bit 7; level, held high for several cycles
IN_src  input  WIDTH  first operand ({SRCH,SRCL})
IN_dst  input  WIDTH  second operand ({DSTH,DSTL})
IN_op  input  4  opcode (keypad value)
OUT_busy  output  1  high from accepted start until DONE
OUT_valid  output  1  result/BCD valid; held in DONE
OUT_err  output  1  divide-by-zero, mul overflow or illegal opcode
OUT_neg  output  1  sub result negative
OUT_result  output  WIDTH  binary result (magnitude for sub)
OUT_bcd  output  4*DIGITS  BCD digits, digit 0 in [3:0]

Behaviour:
- Reset (async, IN_reset=0): state IDLE; all outputs 0; operand/shift regs 0; start_d=0. Reset mid-operation aborts immediately, no partial result kept.
- Start detect: start_d registered each cycle; start_rise = IN_start & ~start_d. A level held high never retriggers.
- States: IDLE, EXEC, CONV, DONE.
- IDLE or DONE + start_rise: latch src/dst/op. Clear valid/err/neg/result/bcd. busy=1. Go to EXEC. Edge where this happens is "edge 0".
- In EXEC/CONV start_rise is ignored (not queued).
- EXEC by opcode:
  - ADD 4'hA: result = src+dst, truncated to WIDTH; carry-out sets err. 1 cycle.
  - SUB 4'hB: if src>=dst, result = src-dst, neg=0; else result = dst-src, neg=1. 1 cycle.
  - MUL 4'hC: shift-add, 16 cycles; 2*WIDTH product; upper half nonzero -> err=1.
  - DIV 4'hD: restoring division, 16 cycles; result = quotient.
  - MOD 4'hE: same as DIV; result = remainder.
  - dst==0 on DIV/MOD -> err=1, detected in the first EXEC cycle.
  - Any other opcode -> err=1 in the first EXEC cycle.
- Any err: skip CONV, go to DONE with result=0, bcd=0, neg=0.
- CONV: double-dabble over WIDTH cycles (add 3 to any digit >=5, then shift); bcd written at the end.
- DONE: busy=0, valid=1; outputs held until next start_rise or reset.
- Latency from edge 0 to valid=1:
  - add/sub: 17 edges (1 EXEC + 16 CONV)
  - mul/div/mod: 32 edges
  - error detected in first EXEC cycle: 1 edge
  - mul overflow: 16 edges
- Outputs registered; no combinational path from inputs to outputs.

Decomposition:
- Package calc_pkg: OP_ADD/OP_SUB/OP_MUL/OP_DIV/OP_MOD/KEY_EQ(4'hF) constants, exec state enum, WIDTH default. Key-entry FSM reuses the opcode constants.
- Sub-module bin2bcd_seq: start/busy/done handshake, WIDTH-cycle double-dabble. Instantiated once; CONV waits on its done.

Test Plan:
- Reset mid-MUL (assert IN_reset at edge 5) -> all outputs 0, IDLE; a new start then gives a correct result.
- src=123, dst=456, op=A, IN_start high 10 cycles -> valid after 17 edges, result=579, bcd=0x00579, err=0, neg=0; start held high causes no second run.
- src=12, dst=999, op=B -> result=987, neg=1, bcd=0x00987.
- src=999, dst=999, op=C -> valid after 32 edges, result=998001 truncated? No: overflow, err=1, result=0, valid after 16 edges. Then src=255, dst=255, op=C -> result=65025, bcd=0x65025, err=0.
- src=999, dst=7, op=D -> result=142; same operands with op=E -> result=5; dst=0, op=D -> err=1, valid after 1 edge, bcd=0.
- op=4'h3 -> err=1; start_rise during EXEC of a DIV -> ignored, DIV result unchanged.
